// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table with 2-bit saturating counters and a tagged
// target buffer; IF looks up combinationally, ID writes back resolved outcomes.
module branch_predictor_bht #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int PERF_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [XLEN-1:0]   lk_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_target_o,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [XLEN-1:0]   upd_pred_target_i,
  output logic              mispredict_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  input  logic              flush_all_i,
  input  logic              stats_clr_i,
  output logic [PERF_W-1:0] br_count_o,
  output logic [PERF_W-1:0] mispred_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];

  logic [IDX_W-1:0]  lkIdx, updIdx;
  logic [TAG_W-1:0]  lkTag, updTag;
  logic              updHit;
  logic              entryWe, targetWe;
  logic              valid_d;
  logic [TAG_W-1:0]  tag_d;
  logic [1:0]        ctr_d;
  logic [PERF_W-1:0] brCount_q, brCount_d;
  logic [PERF_W-1:0] mispredCount_q, mispredCount_d;

  assign lkIdx  = lk_pc_i[IDX_W+1:2];
  assign lkTag  = lk_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign updIdx = upd_pc_i[IDX_W+1:2];
  assign updTag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign pred_hit_o    = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag);
  assign pred_taken_o  = pred_hit_o && ctr_q[lkIdx][1];
  assign pred_target_o = pred_taken_o ? target_q[lkIdx] : lk_pc_i + XLEN'(4);

  assign mispredict_o  = upd_valid_i &&
                         ((upd_taken_i != upd_pred_taken_i) ||
                          (upd_taken_i && (upd_target_i != upd_pred_target_i)));
  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);

  assign updHit   = valid_q[updIdx] && (tag_q[updIdx] == updTag);
  assign targetWe = upd_valid_i && !flush_all_i && upd_taken_i;

  always_comb begin
    entryWe = 1'b0;
    valid_d = valid_q[updIdx];
    tag_d   = tag_q[updIdx];
    ctr_d   = ctr_q[updIdx];
    if (upd_valid_i && !flush_all_i) begin
      if (updHit) begin
        entryWe = 1'b1;
        if (upd_taken_i) begin
          ctr_d = (ctr_q[updIdx] == 2'd3) ? 2'd3 : ctr_q[updIdx] + 2'd1;
        end else begin
          ctr_d = (ctr_q[updIdx] == 2'd0) ? 2'd0 : ctr_q[updIdx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        // Not-taken misses never allocate; a taken miss replaces the entry.
        entryWe = 1'b1;
        valid_d = 1'b1;
        tag_d   = updTag;
        ctr_d   = 2'd2;
      end
    end
  end

  always_comb begin
    brCount_d      = brCount_q;
    mispredCount_d = mispredCount_q;
    if (stats_clr_i) begin
      brCount_d      = '0;
      mispredCount_d = '0;
    end else begin
      if (upd_valid_i && (brCount_q != {PERF_W{1'b1}})) begin
        brCount_d = brCount_q + PERF_W'(1);
      end
      if (mispredict_o && (mispredCount_q != {PERF_W{1'b1}})) begin
        mispredCount_d = mispredCount_q + PERF_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= 2'd1;
      end
    end else if (flush_all_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (entryWe) begin
      valid_q[updIdx] <= valid_d;
      tag_q[updIdx]   <= tag_d;
      ctr_q[updIdx]   <= ctr_d;
    end
  end

  // Targets are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (targetWe) begin
      target_q[updIdx] <= upd_target_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      brCount_q      <= '0;
      mispredCount_q <= '0;
    end else begin
      brCount_q      <= brCount_d;
      mispredCount_q <= mispredCount_d;
    end
  end

  assign br_count_o      = brCount_q;
  assign mispred_count_o = mispredCount_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_branch_predictor_bht;

  localparam int XLEN = 64;
  localparam int PW   = 4;

  localparam int S_HIT = 0, S_TAKEN = 1, S_TGT = 2, S_MISP = 3, S_REDIR = 4, S_BR = 5, S_MP = 6;

  logic            clk, rstN;
  logic [XLEN-1:0] lkPc;
  logic            predHit, predTaken;
  logic [XLEN-1:0] predTarget;
  logic            updValid, updTaken, updPredTaken;
  logic [XLEN-1:0] updPc, updTarget, updPredTarget;
  logic            mispredict;
  logic [XLEN-1:0] redirectPc;
  logic            flushAll, statsClr;
  logic [PW-1:0]   brCount, mispredCount;

  branch_predictor_bht #(.XLEN(XLEN), .ENTRIES(64), .TAG_W(8), .PERF_W(PW)) dut (
    .clk_i(clk), .rst_ni(rstN), .lk_pc_i(lkPc),
    .pred_hit_o(predHit), .pred_taken_o(predTaken), .pred_target_o(predTarget),
    .upd_valid_i(updValid), .upd_pc_i(updPc), .upd_taken_i(updTaken),
    .upd_target_i(updTarget), .upd_pred_taken_i(updPredTaken),
    .upd_pred_target_i(updPredTarget), .mispredict_o(mispredict),
    .redirect_pc_o(redirectPc), .flush_all_i(flushAll), .stats_clr_i(statsClr),
    .br_count_o(brCount), .mispred_count_o(mispredCount)
  );

  typedef struct {
    int              cyc;
    int              sel;
    logic [XLEN-1:0] exp;
    string           name;
  } exp_t;

  exp_t            sbQ[$];
  int              cycleCnt = 0;
  int              checks   = 0;
  int              errors   = 0;
  exp_t            monE;
  logic [XLEN-1:0] monAct;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Monitor: every negedge, compare everything scheduled for the current cycle.
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc <= cycleCnt) begin
      monE = sbQ.pop_front();
      case (monE.sel)
        S_HIT:   monAct = XLEN'(predHit);
        S_TAKEN: monAct = XLEN'(predTaken);
        S_TGT:   monAct = predTarget;
        S_MISP:  monAct = XLEN'(mispredict);
        S_REDIR: monAct = redirectPc;
        S_BR:    monAct = XLEN'(brCount);
        default: monAct = XLEN'(mispredCount);
      endcase
      checks++;
      if (monAct !== monE.exp) begin
        errors++;
        $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
                 monE.name, cycleCnt, monAct, monE.exp);
      end
    end
  end

  task automatic checkOutput(input int sel, input logic [XLEN-1:0] exp, input string name);
    exp_t e;
    e.cyc  = cycleCnt;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sbQ.push_back(e);
  endtask

  task automatic checkLookup(input logic [XLEN-1:0] pc, input logic hit, input logic tk,
                             input logic [XLEN-1:0] tgt, input string name);
    lkPc = pc;
    checkOutput(S_HIT,   XLEN'(hit), {name, "_hit"});
    checkOutput(S_TAKEN, XLEN'(tk),  {name, "_taken"});
    checkOutput(S_TGT,   tgt,        {name, "_target"});
  endtask

  task automatic checkCounts(input int br, input int mp, input string name);
    checkOutput(S_BR, XLEN'(br), {name, "_br_count"});
    checkOutput(S_MP, XLEN'(mp), {name, "_mispred_count"});
  endtask

  task automatic applyStimulus(input logic [XLEN-1:0] pc, input logic tk,
                               input logic [XLEN-1:0] tgt, input logic pt,
                               input logic [XLEN-1:0] ptg);
    updValid      = 1'b1;
    updPc         = pc;
    updTaken      = tk;
    updTarget     = tgt;
    updPredTaken  = pt;
    updPredTarget = ptg;
  endtask

  task automatic idle();
    updValid = 1'b0;
    updTaken = 1'b0;
    updPredTaken = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0; lkPc = 64'h100; flushAll = 1'b0; statsClr = 1'b0;
    updPc = '0; updTarget = '0; updPredTarget = '0;
    idle();
    nextCycle();
    nextCycle();
    rstN = 1'b1;

    // Reset state
    checkLookup(64'h100, 1'b0, 1'b0, 64'h104, "reset");
    checkCounts(0, 0, "reset");
    checkOutput(S_MISP, 64'd0, "reset_mispredict");
    nextCycle();

    // Taken miss allocates; same-cycle lookup still sees the old (empty) entry
    applyStimulus(64'h100, 1'b1, 64'h40, 1'b0, 64'h104);
    checkOutput(S_MISP, 64'd1, "alloc_mispredict");
    checkOutput(S_REDIR, 64'h40, "alloc_redirect");
    checkLookup(64'h100, 1'b0, 1'b0, 64'h104, "alloc_nobypass");
    nextCycle();
    idle();
    checkLookup(64'h100, 1'b1, 1'b1, 64'h40, "alloc_after");
    checkCounts(1, 1, "alloc_after");
    nextCycle();

    // Two not-taken resolutions: ctr 2 -> 1 -> 0
    applyStimulus(64'h100, 1'b0, 64'h0, 1'b1, 64'h40);
    checkOutput(S_MISP, 64'd1, "nt1_mispredict");
    checkOutput(S_REDIR, 64'h104, "nt1_redirect");
    nextCycle();
    applyStimulus(64'h100, 1'b0, 64'h0, 1'b0, 64'h104);
    checkOutput(S_MISP, 64'd0, "nt2_mispredict");
    checkOutput(S_REDIR, 64'h104, "nt2_redirect");
    checkLookup(64'h100, 1'b1, 1'b0, 64'h104, "nt2_ctr1");
    nextCycle();
    idle();
    checkLookup(64'h100, 1'b1, 1'b0, 64'h104, "nt_after");
    checkCounts(3, 2, "nt_after");
    nextCycle();

    // Lower saturation: another not-taken holds ctr at 0
    applyStimulus(64'h100, 1'b0, 64'h0, 1'b0, 64'h104);
    checkOutput(S_MISP, 64'd0, "sat0_mispredict");
    nextCycle();
    applyStimulus(64'h100, 1'b1, 64'h48, 1'b0, 64'h104);
    checkOutput(S_MISP, 64'd1, "t1_mispredict");
    checkOutput(S_REDIR, 64'h48, "t1_redirect");
    checkLookup(64'h100, 1'b1, 1'b0, 64'h104, "sat0_ctr0");
    nextCycle();
    // Direction right but target wrong still mispredicts
    applyStimulus(64'h100, 1'b1, 64'h48, 1'b1, 64'h40);
    checkOutput(S_MISP, 64'd1, "tgtwrong_mispredict");
    checkLookup(64'h100, 1'b1, 1'b0, 64'h104, "t2_ctr1");
    nextCycle();
    applyStimulus(64'h100, 1'b1, 64'h48, 1'b1, 64'h48);
    checkOutput(S_MISP, 64'd0, "correct_mispredict");
    checkLookup(64'h100, 1'b1, 1'b1, 64'h48, "t3_ctr2");
    nextCycle();
    applyStimulus(64'h100, 1'b1, 64'h48, 1'b1, 64'h48);
    nextCycle();
    // Upper saturation: ctr 3 -> 3, then one not-taken leaves it at 2 (still taken)
    applyStimulus(64'h100, 1'b0, 64'h0, 1'b1, 64'h48);
    checkOutput(S_MISP, 64'd1, "sat3_nt_mispredict");
    nextCycle();
    idle();
    checkLookup(64'h100, 1'b1, 1'b1, 64'h48, "sat3_after");
    checkCounts(9, 5, "sat3_after");
    nextCycle();

    // Same index, new tag replaces the entry
    applyStimulus(64'h200, 1'b1, 64'h80, 1'b0, 64'h204);
    checkLookup(64'h200, 1'b0, 1'b0, 64'h204, "replace_nobypass");
    nextCycle();
    idle();
    checkLookup(64'h100, 1'b0, 1'b0, 64'h104, "replace_old");
    nextCycle();
    checkLookup(64'h200, 1'b1, 1'b1, 64'h80, "replace_new");
    nextCycle();
    // Not-taken miss must leave the resident entry alone
    applyStimulus(64'h100, 1'b0, 64'h0, 1'b0, 64'h104);
    nextCycle();
    idle();
    checkLookup(64'h200, 1'b1, 1'b1, 64'h80, "ntmiss_untouched");
    checkCounts(11, 6, "ntmiss_untouched");
    nextCycle();

    // flush_all beats a same-cycle allocation; counters still advance
    flushAll = 1'b1;
    applyStimulus(64'h300, 1'b1, 64'hC0, 1'b0, 64'h304);
    nextCycle();
    flushAll = 1'b0;
    idle();
    checkLookup(64'h100, 1'b0, 1'b0, 64'h104, "flush_100");
    checkCounts(12, 7, "flush");
    nextCycle();
    checkLookup(64'h300, 1'b0, 1'b0, 64'h304, "flush_300");
    nextCycle();
    checkLookup(64'h200, 1'b0, 1'b0, 64'h204, "flush_200");
    nextCycle();

    // 20 mispredicting updates saturate both 4-bit counters
    for (int i = 0; i < 20; i++) begin
      applyStimulus(64'h400, 1'b1, 64'h10, 1'b0, 64'h404);
      nextCycle();
    end
    idle();
    checkCounts(15, 15, "perf_sat");
    checkLookup(64'h400, 1'b1, 1'b1, 64'h10, "perf_sat_entry");
    nextCycle();

    // stats_clr beats a concurrent increment and leaves the table intact
    statsClr = 1'b1;
    applyStimulus(64'h400, 1'b1, 64'h10, 1'b0, 64'h404);
    nextCycle();
    statsClr = 1'b0;
    idle();
    checkCounts(0, 0, "stats_clr");
    checkLookup(64'h400, 1'b1, 1'b1, 64'h10, "stats_clr_entry");
    nextCycle();
    applyStimulus(64'h400, 1'b1, 64'h10, 1'b0, 64'h404);
    nextCycle();
    idle();
    checkCounts(1, 1, "post_clr");
    nextCycle();

    // Asynchronous reset mid-cycle empties the table immediately
    #1;
    rstN = 1'b0;
    checkLookup(64'h400, 1'b0, 1'b0, 64'h404, "async_rst");
    checkCounts(0, 0, "async_rst");
    @(negedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(64'h400, 1'b1, 64'h20, 1'b1, 64'h20);
    nextCycle();
    idle();
    checkLookup(64'h400, 1'b1, 1'b1, 64'h20, "first_after_rst");
    checkCounts(1, 0, "first_after_rst");
    nextCycle();
    nextCycle();

    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
